// File: rtl/pipelined_addsub.sv
// pipelined_addsub: pipelined two's-complement adder/subtractor, valid/ready both sides.
// Ports: clk, rst_n, in_valid/in_ready, a, b, sub, cin; out_valid/out_ready, s, cout, ovf.
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int SEG = WIDTH / STAGES;
   localparam int L   = STAGES - 1;
   localparam int MSB = WIDTH - 1;

   if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_bad
      $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
   end

   // Per-stage registers: remaining operand bits, assembled sum, segment carry.
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  bp_q  [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [STAGES-1:0] c_q;
   logic [STAGES-1:0] sub_q;
   logic [STAGES-1:0] v_q;

   // Stage inputs: stage 0 from the ports, stage k from register k-1.
   logic [WIDTH-1:0]  a_src   [STAGES];
   logic [WIDTH-1:0]  bp_src  [STAGES];
   logic [WIDTH-1:0]  sum_src [STAGES];
   logic [STAGES-1:0] c_src;
   logic [STAGES-1:0] sub_src;
   logic [STAGES-1:0] v_src;

   logic [WIDTH-1:0]  sum_nx [STAGES];
   logic [STAGES-1:0] c_nx;

   logic stall;

   assign stall    = v_q[L] && !out_ready;
   assign in_ready = !stall;

   always_comb begin
      a_src[0]   = a;
      bp_src[0]  = sub ? ~b : b;
      sum_src[0] = '0;
      c_src[0]   = sub ? ~cin : cin;
      sub_src[0] = sub;
      v_src[0]   = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_src[k]   = a_q[k-1];
         bp_src[k]  = bp_q[k-1];
         sum_src[k] = sum_q[k-1];
         c_src[k]   = c_q[k-1];
         sub_src[k] = sub_q[k-1];
         v_src[k]   = v_q[k-1];
      end
   end

   // One SEG-bit ripple segment per stage; this is the critical path.
   always_comb begin
      logic [SEG:0] seg;
      seg = '0;
      for (int k = 0; k < STAGES; k++) begin
         seg = {1'b0, a_src[k][k*SEG +: SEG]}
             + {1'b0, bp_src[k][k*SEG +: SEG]}
             + {{SEG{1'b0}}, c_src[k]};
         sum_nx[k] = sum_src[k];
         sum_nx[k][k*SEG +: SEG] = seg[SEG-1:0];
         c_nx[k] = seg[SEG];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            bp_q[k]  <= '0;
            sum_q[k] <= '0;
         end
         c_q   <= '0;
         sub_q <= '0;
         v_q   <= '0;
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_src[k];
            bp_q[k]  <= bp_src[k];
            sum_q[k] <= sum_nx[k];
         end
         c_q   <= c_nx;
         sub_q <= sub_src;
         v_q   <= v_src;
      end
   end

   assign out_valid = v_q[L];
   assign s         = sum_q[L];
   // Subtraction ran as A + ~B + ~cin, so the raw carry is inverted borrow.
   assign cout      = sub_q[L] ^ c_q[L];
   assign ovf       = (a_q[L][MSB] == bp_q[L][MSB])
                   && (sum_q[L][MSB] != a_q[L][MSB]);

endmodule
